// File: rtl/sync_handshake_rx.sv
// sync_handshake_rx: receives a 4-phase req/ack transfer from a foreign clock
// domain, synchronizes req and presents the captured word on a local valid/ready port.
//
// Ports:
//   clk, reset_            local clock, async active-low reset
//   req_async, data_async  sender request level and data (foreign domain)
//   ack                    acknowledge level back to the sender (flop output)
//   valid, ready, data     local consumer handshake and captured word
//   proto_err              1-cycle pulse when req drops before the word is taken
//   xfer_cnt               completed transfers, saturating at 255
module sync_handshake_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             req_async,
  input  logic [WIDTH-1:0] data_async,
  output logic             ack,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             proto_err,
  output logic [7:0]       xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [SYNC_STAGES-1:0] sync;
  logic                   req_s;

  logic             ack_n;
  logic             valid_n;
  logic             err_n;
  logic [WIDTH-1:0] data_n;
  logic [7:0]       cnt_n;

  // req_async is only ever seen through this chain
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req_async};
    end
  end

  assign req_s = sync[SYNC_STAGES-1];

  always_comb begin
    state_n = state;
    ack_n   = 1'b0;
    valid_n = 1'b0;
    err_n   = 1'b0;
    data_n  = data;
    cnt_n   = xfer_cnt;
    unique case (state)
      IDLE: begin
        if (req_s) begin
          state_n = VALID;
          valid_n = 1'b1;
          data_n  = data_async;
        end
      end
      VALID: begin
        // a sender abort wins over a same-cycle consumer accept
        if (!req_s) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (ready) begin
          state_n = ACK;
          ack_n   = 1'b1;
          if (xfer_cnt != 8'hFF) begin
            cnt_n = xfer_cnt + 8'd1;
          end
        end else begin
          valid_n = 1'b1;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_n = IDLE;
        end else begin
          ack_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // outputs are registered copies of the next-state decode
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= IDLE;
      ack       <= 1'b0;
      valid     <= 1'b0;
      proto_err <= 1'b0;
      data      <= '0;
      xfer_cnt  <= '0;
    end else begin
      state     <= state_n;
      ack       <= ack_n;
      valid     <= valid_n;
      proto_err <= err_n;
      data      <= data_n;
      xfer_cnt  <= cnt_n;
    end
  end

endmodule

// File: tb/tb_sync_handshake_rx.sv
// tb_sync_handshake_rx: directed scenarios plus a randomized sender/consumer
// checked every cycle against a behavioural model of the receiver.
module tb_sync_handshake_rx;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset_;
  logic         req_async;
  logic [W-1:0] data_async;
  logic         ack;
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         proto_err;
  logic [7:0]   xfer_cnt;

  int n_chk = 0;
  int n_err = 0;
  bit mon_on = 1'b0;

  sync_handshake_rx #(
    .WIDTH(W),
    .SYNC_STAGES(S)
  ) dut (
    .clk(clk),
    .reset_(reset_),
    .req_async(req_async),
    .data_async(data_async),
    .ack(ack),
    .valid(valid),
    .ready(ready),
    .data(data),
    .proto_err(proto_err),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: req is seen S cycles late; a seen request fills the
  // holding slot, the consumer drains it, and release clears the ack.
  logic [S-1:0] hist;
  logic         m_valid;
  logic         m_ack;
  logic         m_err;
  logic [W-1:0] m_data;
  int           n_done;

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      hist    <= '0;
      m_valid <= 1'b0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_data  <= '0;
      n_done  <= 0;
    end else begin
      hist  <= {hist[S-2:0], req_async};
      m_err <= 1'b0;
      if (m_valid) begin
        if (!hist[S-1]) begin
          m_valid <= 1'b0;
          m_err   <= 1'b1;
        end else if (ready) begin
          m_valid <= 1'b0;
          m_ack   <= 1'b1;
          n_done  <= n_done + 1;
        end
      end else if (m_ack) begin
        if (!hist[S-1]) m_ack <= 1'b0;
      end else if (hist[S-1]) begin
        m_valid <= 1'b1;
        m_data  <= data_async;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("cycle", {ack, valid, proto_err, xfer_cnt, data},
          {m_ack, m_valid, m_err, (n_done > 255) ? 8'd255 : n_done[7:0],
           m_data});
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int k;
    k = 0;
    while (ack !== lvl && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk(tag, ack, lvl);
  endtask

  int acks;
  int err_seen;

  initial begin
    reset_     = 1'b0;
    req_async  = 1'b0;
    data_async = '0;
    ready      = 1'b0;
    edges(3);
    chk("rst_ack", ack, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_err", proto_err, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_cnt", xfer_cnt, 8'h00);
    mon_on = 1'b1;
    reset_ = 1'b1;
    edges(1);

    // basic transfer
    ready      = 1'b1;
    data_async = 8'hA5;
    req_async  = 1'b1;
    edges(2);
    chk("basic_pre", valid, 1'b0);
    edges(1);
    chk("basic_valid", valid, 1'b1);
    chk("basic_data", data, 8'hA5);
    edges(1);
    chk("basic_vdrop", valid, 1'b0);
    chk("basic_ack", ack, 1'b1);
    req_async = 1'b0;
    edges(S + 1);
    chk("basic_ackoff", ack, 1'b0);
    chk("basic_cnt", xfer_cnt, 8'd1);

    // backpressure
    ready     = 1'b0;
    req_async = 1'b1;
    edges(S + 1);
    chk("bp_valid", valid, 1'b1);
    data_async = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      chk("bp_hold_v", valid, 1'b1);
      chk("bp_hold_d", data, 8'hA5);
      chk("bp_hold_a", ack, 1'b0);
    end
    ready = 1'b1;
    edges(1);
    chk("bp_ack", ack, 1'b1);
    req_async = 1'b0;
    wait_ack(1'b0, "bp_release");
    chk("bp_cnt", xfer_cnt, 8'd2);

    // protocol violation
    ready      = 1'b0;
    data_async = 8'h5A;
    req_async  = 1'b1;
    edges(S + 1);
    chk("pv_valid", valid, 1'b1);
    req_async = 1'b0;
    err_seen  = 0;
    for (int i = 0; i < 8; i++) begin
      edges(1);
      if (proto_err) err_seen++;
      chk("pv_noack", ack, 1'b0);
    end
    chk("pv_pulses", err_seen, 1);
    chk("pv_valid0", valid, 1'b0);
    chk("pv_cnt", xfer_cnt, 8'd2);
    chk("pv_data", data, 8'h5A);

    // randomized sender and consumer
    for (int i = 0; i < 3000; i++) begin
      ready = 1'($urandom_range(0, 1));
      if (!req_async && !ack) begin
        if ($urandom_range(0, 2) == 0) begin
          data_async = W'($urandom);
          req_async  = 1'b1;
        end
      end else if (req_async && ack) begin
        if ($urandom_range(0, 1) == 0) req_async = 1'b0;
      end else if (req_async && $urandom_range(0, 39) == 0) begin
        req_async = 1'b0;
      end
      edges(1);
    end
    req_async = 1'b0;
    edges(6);

    // reset while in ACK with req held
    ready      = 1'b1;
    data_async = 8'hC3;
    req_async  = 1'b1;
    wait_ack(1'b1, "mr_ack");
    #2;
    reset_ = 1'b0;
    #1;
    chk("mr_ack0", ack, 1'b0);
    chk("mr_valid0", valid, 1'b0);
    chk("mr_err0", proto_err, 1'b0);
    chk("mr_cnt0", xfer_cnt, 8'd0);
    edges(1);
    chk("mr_err_hold", proto_err, 1'b0);
    reset_ = 1'b1;
    edges(S);
    chk("mr_wait", valid, 1'b0);
    edges(1);
    chk("mr_valid", valid, 1'b1);
    chk("mr_data", data, 8'hC3);
    req_async = 1'b0;
    wait_ack(1'b0, "mr_release");

    // saturation
    acks = 0;
    for (int i = 0; i < 260; i++) begin
      data_async = W'($urandom);
      req_async  = 1'b1;
      wait_ack(1'b1, "sat_ack");
      if (ack) acks++;
      req_async = 1'b0;
      wait_ack(1'b0, "sat_rel");
    end
    chk("sat_acks", acks, 260);
    chk("sat_cnt", xfer_cnt, 8'd255);
    edges(5);
    chk("sat_hold", xfer_cnt, 8'd255);

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
